// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types and constants for the calculator execute block.
//                Holds the opcode encoding, the controller state encoding,
//                the iteration count of the multi-cycle operations and the
//                value reported for a divide by zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Number of ITER cycles for the iterative operations (one bit per cycle).
    localparam int ITER_COUNT = 16;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    // Result reported when a division is attempted with a zero divisor.
    localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ITER = 2'b10,
        ST_DONE = 2'b11
    } calc_state_e;

endpackage
`default_nettype wire

// File: rtl/calc_iter_step.sv
`default_nettype none
// ============================================================================
//  Module      : calc_iter_step
//  Description : One combinational step of the iterative datapath. Both
//                operations consume the shift register MSB first:
//                  mul : acc = (acc << 1) + (shreg[15] ? operand : 0)
//                        shreg shifts left, zero fill.
//                  div : restoring division; acc[15:0] is the partial
//                        remainder, shreg holds the dividend shifting out and
//                        the quotient bits shifting in.
//  Ports       : i_is_div  - select divide step (else multiply step)
//                i_acc     - accumulator / partial remainder in
//                i_shreg   - multiplier / dividend-quotient register in
//                i_operand - multiplicand / divisor
//                o_acc     - next accumulator / partial remainder
//                o_shreg   - next shift register
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_iter_step (
    input  logic        i_is_div,
    input  logic [31:0] i_acc,
    input  logic [15:0] i_shreg,
    input  logic [15:0] i_operand,
    output logic [31:0] o_acc,
    output logic [15:0] o_shreg
);

    logic [31:0] w_mul_acc;
    logic [16:0] w_trial;
    logic [15:0] w_rem_sub;
    logic        w_fits;

    assign w_mul_acc = (i_acc << 1) + (i_shreg[15] ? {16'h0000, i_operand} : 32'h0000_0000);

    // The shifted remainder needs 17 bits for the compare. When the divisor
    // fits, the difference is below the divisor and so fits in 16 bits,
    // which lets the subtraction itself stay 16 bits wide.
    assign w_trial   = {i_acc[15:0], i_shreg[15]};
    assign w_fits    = (w_trial >= {1'b0, i_operand});
    assign w_rem_sub = w_trial[15:0] - i_operand;

    always_comb begin
        o_acc   = w_mul_acc;
        o_shreg = {i_shreg[14:0], 1'b0};
        if (i_is_div) begin
            o_acc   = {16'h0000, (w_fits ? w_rem_sub : w_trial[15:0])};
            o_shreg = {i_shreg[14:0], w_fits};
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_execute_controller.sv
`default_nettype none
// ============================================================================
//  Module      : calc_execute_controller
//  Description : Execute controller of a 16-bit calculator. Operands and the
//                opcode are latched from the switches; a rising edge of
//                compute_req starts an add/sub (single cycle), or a mul/div
//                (16 iterations). The result is published on entry to DONE.
//  Ports       : clk             - system clock, rising edge
//                reset           - asynchronous active-high reset
//                switches[15:0]  - operand / opcode source
//                store_num1      - load operand A from switches
//                store_num2      - load operand B from switches
//                store_operation - load opcode from switches[1:0]
//                compute_req     - start request (rising edge)
//                busy            - computation in progress (LOAD/ITER)
//                done            - one-cycle completion pulse
//                result[31:0]    - last completed answer
//                div_error       - last completion was a divide by zero
//                op_code[1:0]    - currently stored opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_execute_controller
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] switches,
    input  logic        store_num1,
    input  logic        store_num2,
    input  logic        store_operation,
    input  logic        compute_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_error,
    output logic [1:0]  op_code
);

    calc_state_e      r_state;
    calc_state_e      w_next_state;

    logic [15:0]      r_num_a;
    logic [15:0]      r_num_b;
    calc_op_e         r_op;

    logic             r_req_prev;
    logic             r_armed;
    logic             w_req_edge;

    logic [CNT_W-1:0] r_count;
    calc_op_e         r_snap_op;
    logic [15:0]      r_snap_b;
    logic [31:0]      r_acc;
    logic [15:0]      r_shreg;

    logic [31:0]      r_result;
    logic             r_div_error;

    logic [16:0]      w_sum;
    logic [16:0]      w_diff;
    logic [31:0]      w_quick_result;
    logic             w_quick_is_div0;

    logic [31:0]      w_step_acc;
    logic [15:0]      w_step_shreg;
    logic             w_snap_is_div;

    // ------------------------------------------------------------------
    // Start detection. r_armed stays low after reset until compute_req has
    // been seen low, so a level held through reset cannot pose as an edge.
    // ------------------------------------------------------------------
    assign w_req_edge = compute_req & ~r_req_prev & r_armed;

    // ------------------------------------------------------------------
    // Single-cycle results, evaluated from the stored operands in LOAD
    // (stores are blocked while busy, so they equal the snapshot).
    // ------------------------------------------------------------------
    assign w_sum           = {1'b0, r_num_a} + {1'b0, r_num_b};
    assign w_diff          = {1'b0, r_num_a} - {1'b0, r_num_b};
    assign w_quick_is_div0 = (r_op == OP_DIV) && (r_num_b == 16'h0000);

    always_comb begin
        w_quick_result = DIV0_RESULT;
        case (r_op)
            OP_ADD:  w_quick_result = {15'd0, w_sum};
            OP_SUB:  w_quick_result = {{15{w_diff[16]}}, w_diff};
            default: w_quick_result = DIV0_RESULT;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative step
    // ------------------------------------------------------------------
    assign w_snap_is_div = (r_snap_op == OP_DIV);

    calc_iter_step u_iter_step (
        .i_is_div  (w_snap_is_div),
        .i_acc     (r_acc),
        .i_shreg   (r_shreg),
        .i_operand (r_snap_b),
        .o_acc     (w_step_acc),
        .o_shreg   (w_step_shreg)
    );

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_edge) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if ((r_op == OP_ADD) || (r_op == OP_SUB) || w_quick_is_div0) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_ITER;
                end
            end
            ST_ITER: begin
                busy = 1'b1;
                if (r_count == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, latches and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_num_a     <= 16'h0000;
            r_num_b     <= 16'h0000;
            r_op        <= OP_ADD;
            r_req_prev  <= 1'b0;
            r_armed     <= 1'b0;
            r_count     <= '0;
            r_snap_op   <= OP_ADD;
            r_snap_b    <= 16'h0000;
            r_acc       <= 32'h0000_0000;
            r_shreg     <= 16'h0000;
            r_result    <= 32'h0000_0000;
            r_div_error <= 1'b0;
        end else begin
            // History always follows the input, so an edge landing in DONE
            // is consumed here and is not replayed once back in IDLE.
            r_req_prev <= compute_req;
            r_armed    <= r_armed | ~compute_req;
            r_state    <= w_next_state;

            if (!busy) begin
                if (store_num1) begin
                    r_num_a <= switches;
                end
                if (store_num2) begin
                    r_num_b <= switches;
                end
                if (store_operation) begin
                    r_op <= calc_op_e'(switches[1:0]);
                end
            end

            case (r_state)
                ST_LOAD: begin
                    r_count   <= CNT_W'(ITER_COUNT - 1);
                    r_snap_op <= r_op;
                    r_snap_b  <= r_num_b;
                    r_shreg   <= r_num_a;
                    r_acc     <= 32'h0000_0000;
                    if (w_next_state == ST_DONE) begin
                        r_result    <= w_quick_result;
                        r_div_error <= w_quick_is_div0;
                    end
                end
                ST_ITER: begin
                    r_acc   <= w_step_acc;
                    r_shreg <= w_step_shreg;
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end else begin
                        // Last step: publish straight from the step outputs.
                        r_result    <= w_snap_is_div ? {w_step_acc[15:0], w_step_shreg}
                                                     : w_step_acc;
                        r_div_error <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = r_result;
    assign div_error = r_div_error;
    assign op_code   = r_op;

endmodule
`default_nettype wire

// File: tb/tb_calc_execute_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_execute_controller
//  Description : Directed self-checking bench for calc_execute_controller.
//                Inputs change and outputs are sampled on the falling edge.
//                Latency is counted in falling edges after compute_req is
//                raised, so a count of N means done was seen in cycle k+N
//                where clock k is the edge that registers the request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_execute_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] switches;
    logic        store_num1;
    logic        store_num2;
    logic        store_operation;
    logic        compute_req;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_error;
    logic [1:0]  op_code;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          lat;
    int          nbusy;
    int          ndone;
    logic [31:0] res;
    logic        derr;

    calc_execute_controller dut (
        .clk             (clk),
        .reset           (reset),
        .switches        (switches),
        .store_num1      (store_num1),
        .store_num2      (store_num2),
        .store_operation (store_operation),
        .compute_req     (compute_req),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .div_error       (div_error),
        .op_code         (op_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge.
    task automatic load_ops(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        switches = a;  store_num1 = 1'b1;
        @(negedge clk);
        store_num1 = 1'b0;
        switches = b;  store_num2 = 1'b1;
        @(negedge clk);
        store_num2 = 1'b0;
        switches = {14'h0000, op};  store_operation = 1'b1;
        @(negedge clk);
        store_operation = 1'b0;
        switches = 16'h0000;
    endtask

    // One-cycle request pulse; waits (bounded) for done, then one more cycle.
    task automatic run_op(output int o_lat, output int o_busy,
                          output logic [31:0] o_res, output logic o_derr);
        o_lat  = -1;
        o_busy = 0;
        o_res  = 32'hDEAD_BEEF;
        o_derr = 1'bx;
        compute_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) compute_req = 1'b0;
            if (busy) o_busy++;
            if (done) begin
                o_lat  = i;
                o_res  = result;
                o_derr = div_error;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;  switches = 16'h0000;  store_num1 = 1'b0;  store_num2 = 1'b0;
        store_operation = 1'b0;  compute_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    {31'd0, busy},      32'd0);
        chk("rst_done",    {31'd0, done},      32'd0);
        chk("rst_result",  result,             32'd0);
        chk("rst_diverr",  {31'd0, div_error}, 32'd0);
        chk("rst_opcode",  {30'd0, op_code},   32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 3 - 5 -> -2
        load_ops(16'd3, 16'd5, 2'b01);
        chk("sub_opcode", {30'd0, op_code}, 32'd1);
        run_op(lat, nbusy, res, derr);
        chk("sub_lat",    lat,               32'd2);
        chk("sub_busy",   nbusy,             32'd1);
        chk("sub_result", res,               32'hFFFF_FFFE);
        chk("sub_diverr", {31'd0, derr},     32'd0);
        chk("sub_pulse",  {31'd0, done},     32'd0);
        chk("sub_hold",   result,            32'hFFFF_FFFE);

        // 17-bit carry of add
        load_ops(16'hFFFF, 16'hFFFF, 2'b00);
        run_op(lat, nbusy, res, derr);
        chk("add_lat",    lat, 32'd2);
        chk("add_result", res, 32'h0001_FFFE);

        // FFFF * FFFF
        load_ops(16'hFFFF, 16'hFFFF, 2'b10);
        run_op(lat, nbusy, res, derr);
        chk("mul_lat",    lat,           32'd18);
        chk("mul_busy",   nbusy,         32'd17);
        chk("mul_result", res,           32'hFFFE_0001);
        chk("mul_pulse",  {31'd0, done}, 32'd0);

        // 100 / 7 = 14 r 2
        load_ops(16'd100, 16'd7, 2'b11);
        run_op(lat, nbusy, res, derr);
        chk("div_lat",    lat,           32'd18);
        chk("div_result", res,           32'h0002_000E);
        chk("div_diverr", {31'd0, derr}, 32'd0);

        // divide by zero (only B changes)
        switches = 16'h0000;  store_num2 = 1'b1;
        @(negedge clk);
        store_num2 = 1'b0;
        run_op(lat, nbusy, res, derr);
        chk("div0_lat",    lat,           32'd2);
        chk("div0_result", res,           32'hFFFF_FFFF);
        chk("div0_diverr", {31'd0, derr}, 32'd1);
        chk("div0_hold",   {31'd0, div_error}, 32'd1);

        // All three stores in one cycle: A=B=0x0102, op=mul
        switches = 16'h0102;  store_num1 = 1'b1;  store_num2 = 1'b1;  store_operation = 1'b1;
        @(negedge clk);
        store_num1 = 1'b0;  store_num2 = 1'b0;  store_operation = 1'b0;  switches = 16'h0000;
        chk("multi_opcode", {30'd0, op_code}, 32'd2);
        run_op(lat, nbusy, res, derr);
        chk("multi_result", res,           32'h0001_0404);
        chk("multi_diverr", {31'd0, derr}, 32'd0);

        // Store and re-request while busy are ignored
        load_ops(16'd300, 16'd200, 2'b10);
        ndone = 0;  res = 32'hDEAD_BEEF;
        compute_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            case (i)
                1: compute_req = 1'b0;
                3: begin switches = 16'h1234; store_num1 = 1'b1; end
                4: begin store_num1 = 1'b0; switches = 16'h0000; end
                6: compute_req = 1'b1;
                7: compute_req = 1'b0;
                default: ;
            endcase
            if (done) begin ndone++; res = result; end
        end
        chk("busy_ign_ndone",  ndone, 32'd1);
        chk("busy_ign_result", res,   32'h0000_EA60);
        switches = 16'h0000;  store_operation = 1'b1;
        @(negedge clk);
        store_operation = 1'b0;
        run_op(lat, nbusy, res, derr);
        chk("busy_ign_operand", res, 32'h0000_01F4);

        // Level held across completion does not retrigger
        ndone = 0;
        compute_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        compute_req = 1'b0;
        @(negedge clk);
        chk("hold_ndone", ndone, 32'd1);

        // Edge arriving in DONE while still high in IDLE is lost
        ndone = 0;  nbusy = 0;
        compute_req = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) compute_req = 1'b0;
            if (i > 2 && busy) nbusy++;
            if (done) begin ndone++; compute_req = 1'b1; end
        end
        compute_req = 1'b0;
        @(negedge clk);
        chk("done_edge_ndone", ndone, 32'd1);
        chk("done_edge_busy",  nbusy, 32'd0);

        // Reset mid-ITER with counter at 7
        load_ops(16'd1000, 16'd999, 2'b10);
        compute_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) compute_req = 1'b0;
        end
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy",   {31'd0, busy},      32'd0);
        chk("arst_result", result,             32'd0);
        chk("arst_opcode", {30'd0, op_code},   32'd0);
        chk("arst_diverr", {31'd0, div_error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;  nbusy = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("post_rst_ndone", ndone, 32'd0);
        chk("post_rst_busy",  nbusy, 32'd0);

        // Request held high through reset release needs a fresh edge
        reset = 1'b1;  compute_req = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nbusy = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (busy || done) nbusy++;
        end
        chk("rst_held_req", nbusy, 32'd0);
        compute_req = 1'b0;
        @(negedge clk);
        load_ops(16'd7, 16'd9, 2'b10);
        run_op(lat, nbusy, res, derr);
        chk("fresh_lat",    lat, 32'd18);
        chk("fresh_result", res, 32'd63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_execute_controller.md
CALC_EXECUTE_CONTROLLER -- requirements
Module: calc_execute_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port switches, input, 16 bits: operand and opcode source.
REQ-004 SHALL have port store_num1, input, 1 bit: level enable, operand A load from switches.
REQ-005 SHALL have port store_num2, input, 1 bit: level enable, operand B load from switches.
REQ-006 SHALL have port store_operation, input, 1 bit: level enable, opcode load from switches[1:0].
REQ-007 SHALL have port compute_req, input, 1 bit: level request; a computation starts on its rising edge only.
REQ-008 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-010 SHALL have port result, output, 32 bits: last completed answer.
REQ-011 SHALL have port div_error, output, 1 bit: last completed operation was a divide by zero.
REQ-012 SHALL have port op_code, output, 2 bits: currently stored opcode, for display.

Function
REQ-013 SHALL latch operand A, operand B or opcode on any clock edge where the corresponding store input is high and busy is low; several stores in the same cycle all take effect.
REQ-014 SHALL encode opcodes as 00 add, 01 sub, 10 mul, 11 div; operands are unsigned 16 bits.
REQ-015 SHALL register compute_req each cycle and detect a rising edge as current high AND previous low.
REQ-016 SHALL implement FSM states IDLE, LOAD, ITER, DONE.
- IDLE->LOAD on a detected edge.
- LOAD: snapshot A, B and opcode; set iteration counter to 15.
- LOAD->DONE for add/sub, and for div with B=0.
- LOAD->ITER for mul and for div with B!=0.
- ITER: 16 cycles, counter 15 down to 0; ITER->DONE when counter=0.
- DONE->IDLE unconditionally.
REQ-017 SHALL drive busy=1 in LOAD and ITER, and done=1 only in DONE.
REQ-018 SHALL meet these latencies, with the edge registered at clock k: add/sub done high in cycle k+2; mul/div done high in cycle k+18; div by zero done high in cycle k+2.
REQ-019 SHALL compute add as zero-extended 17-bit A+B.
REQ-020 SHALL compute sub as A-B in two's complement, sign-extended to 32 bits.
REQ-021 SHALL compute mul by iterative shift-add, one partial product per ITER cycle, giving the 32-bit unsigned product.
REQ-022 SHALL compute div by restoring division, one quotient bit per ITER cycle, giving result = {remainder[15:0], quotient[15:0]}.
REQ-023 SHALL, for div with B=0, set result=32'hFFFF_FFFF and div_error=1; every other completion SHALL clear div_error.
REQ-024 SHALL update result and div_error only on entry to DONE, holding both at all other times.
REQ-025 SHALL ignore compute_req edges and all store inputs while busy; a level held high across completion SHALL NOT retrigger.
REQ-026 SHALL register an edge that arrives while the FSM is in DONE, and act on it only if compute_req is still high with a low history once in IDLE; otherwise the edge is lost.

Reset
REQ-027 SHALL, on reset assertion, immediately return to IDLE and clear busy, done, result, div_error, op_code, operands, counter and the compute_req history register to 0, including mid-ITER; there is no resumption.
REQ-028 SHALL require a fresh rising edge on compute_req after reset deassertion before starting a computation.

Structure
REQ-029 SHALL place the opcode typedef, FSM state enum, ITER_COUNT=16 and the DIV0_RESULT constant in shared package calc_pkg.
REQ-030 SHALL isolate the per-cycle shift-add / restore-subtract step in one sub-module, calc_iter_step; FSM, counter and latches remain in the top module.

Verification
REQ-031 SHALL cover: A=3, B=5, sub, compute_req edge -> done at k+2, result=32'hFFFF_FFFE, div_error=0.
REQ-032 SHALL cover: A=B=16'hFFFF, mul -> busy 17 cycles, done at k+18, result=32'hFFFE_0001.
REQ-033 SHALL cover: A=100, B=7, div -> result=32'h0002_000E; then B=0, div -> result=32'hFFFF_FFFF, div_error=1, done at k+2.
REQ-034 SHALL cover: store_num1 pulsed with switches=16'h1234 and compute_req re-pulsed during ITER -> operand and result unaffected, exactly one done pulse.
REQ-035 SHALL cover: reset asserted at ITER counter=7 -> busy=0 and result=0 asynchronously, and no done pulse afterwards without a new edge.
